// File: rtl/fx_pkg.sv
// Shared definitions for the Q8.8 fixed-point divide path.
package fx_pkg;

    localparam int FX_DW   = 16;
    localparam int FX_FRAC = 8;
    localparam int FX_QW   = FX_DW + FX_FRAC;

    typedef logic signed [15:0] fx_q8_8_t;
    typedef logic signed [23:0] fx_q16_8_t;

    // Saturation limits of the Q16.8 quotient.
    localparam fx_q16_8_t FX_QMAX = 24'sh7FFFFF;
    localparam fx_q16_8_t FX_QMIN = 24'sh800000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fx_div_state_t;

endpackage

// File: rtl/fx_div_step.sv
// One radix-2 restoring-division step on unsigned magnitudes.
module fx_div_step #(
    parameter int DW = 16
) (
    input  logic [DW:0]   rem_in,
    input  logic          num_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW+1:0] trial_s;
    logic [DW:0]   diff_s;

    // Shift the next numerator bit in, then subtract if the divisor fits.
    always_comb begin
        trial_s = {rem_in, num_bit};
        // Only used when trial >= divisor, so the result is below the
        // divisor and fits the DW+1 bit remainder.
        diff_s  = trial_s[DW:0] - {1'b0, divisor};
        if (trial_s >= {2'b00, divisor}) begin
            rem_out = diff_s;
            q_bit   = 1'b1;
        end else begin
            rem_out = trial_s[DW:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/fx_div.sv
// Sequential signed Q8.8 / Q8.8 -> Q16.8 divider, one quotient bit per clock.
module fx_div
    import fx_pkg::*;
#(
    parameter int DW   = FX_DW,
    parameter int FRAC = FX_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_dividend,
    input  logic [DW-1:0]        in_divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW+FRAC-1:0]   out_quotient,
    output logic                 out_div0,
    output logic                 out_ovf
);

    localparam int QW = DW + FRAC;
    localparam int CW = $clog2(QW);
    localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

    fx_div_state_t   state_r;
    logic            sign_r;
    logic [QW-1:0]   work_r;     // numerator bits out at the top, quotient bits in at the bottom
    logic [DW-1:0]   dmag_r;
    logic [DW:0]     rem_r;
    logic [CW-1:0]   cnt_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [QW-1:0]   quot_r;
    logic            div0_r;
    logic            ovf_r;

    logic [DW:0]     dvd_ext_s;
    logic [DW:0]     dsr_ext_s;
    logic [DW:0]     dvd_mag_s;
    logic [DW:0]     dsr_mag_s;
    logic            dvd_zero_s;
    logic            dsr_zero_s;
    logic [QW-1:0]   num_s;
    logic            sign_s;
    logic [QW-1:0]   div0_q_s;
    logic [QW-1:0]   mag_s;
    logic [QW-1:0]   res_q_s;
    logic            res_ovf_s;
    logic [DW:0]     step_rem_s;
    logic            step_q_s;

    fx_div_step #(.DW(DW)) u_step (
        .rem_in  (rem_r),
        .num_bit (work_r[QW-1]),
        .divisor (dmag_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Operand magnitudes (one extra bit so -2^(DW-1) does not wrap) and final sign/saturation.
    always_comb begin
        dvd_ext_s = {in_dividend[DW-1], in_dividend};
        dsr_ext_s = {in_divisor[DW-1], in_divisor};
        if (in_dividend[DW-1]) begin
            dvd_mag_s = -dvd_ext_s;
        end else begin
            dvd_mag_s = dvd_ext_s;
        end
        if (in_divisor[DW-1]) begin
            dsr_mag_s = -dsr_ext_s;
        end else begin
            dsr_mag_s = dsr_ext_s;
        end
        dvd_zero_s = (dvd_mag_s == {(DW+1){1'b0}});
        dsr_zero_s = (dsr_mag_s == {(DW+1){1'b0}});
        num_s      = {dvd_mag_s[DW-1:0], {FRAC{1'b0}}};
        // A zero dividend gives +0 regardless of the divisor sign.
        if (dvd_zero_s) begin
            sign_s = 1'b0;
        end else begin
            sign_s = in_dividend[DW-1] ^ in_divisor[DW-1];
        end
        if (in_dividend[DW-1]) begin
            div0_q_s = QMIN;
        end else begin
            div0_q_s = QMAX;
        end
        // Magnitude as it stands after the final iteration.
        mag_s = {work_r[QW-2:0], step_q_s};
        if (sign_r) begin
            // -2^(QW-1) is representable, so negative results never saturate.
            res_q_s   = -mag_s;
            res_ovf_s = 1'b0;
        end else if (mag_s[QW-1]) begin
            res_q_s   = QMAX;
            res_ovf_s = 1'b1;
        end else begin
            res_q_s   = mag_s;
            res_ovf_s = 1'b0;
        end
    end

    // Control FSM, iteration datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            work_r      <= {QW{1'b0}};
            dmag_r      <= {DW{1'b0}};
            rem_r       <= {(DW+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quot_r      <= {QW{1'b0}};
            div0_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sign_r     <= sign_s;
                        work_r     <= num_s;
                        dmag_r     <= dsr_mag_s[DW-1:0];
                        rem_r      <= {(DW+1){1'b0}};
                        cnt_r      <= CW'(QW - 1);
                        in_ready_r <= 1'b0;
                        ovf_r      <= 1'b0;
                        if (dsr_zero_s) begin
                            state_r <= DONE;
                            quot_r  <= div0_q_s;
                            div0_r  <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            div0_r  <= 1'b0;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    rem_r  <= step_rem_s;
                    work_r <= {work_r[QW-2:0], step_q_s};
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= DONE;
                        quot_r  <= res_q_s;
                        ovf_r   <= res_ovf_s;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_quotient = quot_r;
    assign out_div0     = div0_r;
    assign out_ovf      = ovf_r;

endmodule

// File: tb/tb_fx_div.sv
// Self-checking bench for fx_div: vector table, hand sequences and random ops vs an integer model.
module tb_fx_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_dividend = 16'h0000;
    logic [15:0] in_divisor = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_quotient;
    logic        out_div0;
    logic        out_ovf;

    int errors = 0;
    int checks = 0;
    bit ready_tie = 1'b0;

    fx_div dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_div0     (out_div0),
        .out_ovf      (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dsr;
        logic [23:0] q;
        logic        d0;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the real values.
    task automatic model(input logic [15:0] dvd, input logic [15:0] dsr,
                         output logic [23:0] q, output logic d0, output logic ov);
        longint n;
        longint d;
        longint r;
        n = longint'($signed(dvd)) * 256;
        d = longint'($signed(dsr));
        d0 = 1'b0;
        ov = 1'b0;
        if (d == 0) begin
            d0 = 1'b1;
            q  = (n < 0) ? 24'h800000 : 24'h7FFFFF;
        end else begin
            r = n / d;
            if (r > 8388607) begin
                q  = 24'h7FFFFF;
                ov = 1'b1;
            end else if (r < -8388608) begin
                q  = 24'h800000;
                ov = 1'b1;
            end else begin
                q = r[23:0];
            end
        end
    endtask

    // Issue one operation and check result, flags, latency and the output handshake.
    // hold>0 keeps out_ready low that many cycles while probing with an ignored in_valid.
    task automatic run_check(input string nm, input logic [15:0] dvd, input logic [15:0] dsr,
                             input logic [23:0] eq, input logic ed0, input logic eov,
                             input int elat, input int hold);
        int n;
        logic [23:0] held_q;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk({nm, " in_ready timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        in_dividend = dvd;
        in_divisor  = dsr;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_dividend = 16'($urandom);
        in_divisor  = 16'($urandom);
        chk({nm, " busy after accept"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk({nm, " out_valid timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        if (elat > 0) chk({nm, " latency"}, 32'(n), 32'(elat));
        chk({nm, " quotient"}, 32'(out_quotient), 32'(eq));
        chk({nm, " div0"}, 32'(out_div0), 32'(ed0));
        chk({nm, " ovf"}, 32'(out_ovf), 32'(eov));
        held_q = out_quotient;
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                in_dividend = 16'h0700;
                in_divisor  = 16'h0100;
                in_valid    = 1'b1;
            end
            @(posedge clk); #1;
            chk({nm, " hold valid"}, 32'(out_valid), 32'd1);
            chk({nm, " hold quotient"}, 32'(out_quotient), 32'(held_q));
            chk({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = ready_tie;
        chk({nm, " valid drops"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            chk({nm, " ignored op not run"}, 32'(out_valid), 32'd0);
            chk({nm, " still idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [23:0] mq;
        logic        md0;
        logic        mov;
        logic [15:0] rd;
        logic [15:0] rs;

        tbl[0] = '{16'hAA5A, 16'h4AF0, 24'hFFFEDC, 1'b0, 1'b0, 25};
        tbl[1] = '{16'h0100, 16'h0200, 24'h000080, 1'b0, 1'b0, 25};
        tbl[2] = '{16'h0300, 16'hFF00, 24'hFFFD00, 1'b0, 1'b0, 25};
        tbl[3] = '{16'h0300, 16'h0000, 24'h7FFFFF, 1'b1, 1'b0, 1};
        tbl[4] = '{16'h8000, 16'h0000, 24'h800000, 1'b1, 1'b0, 1};
        tbl[5] = '{16'h8000, 16'hFFFF, 24'h7FFFFF, 1'b0, 1'b1, 25};
        tbl[6] = '{16'h8000, 16'h0001, 24'h800000, 1'b0, 1'b0, 25};
        tbl[7] = '{16'h0000, 16'hF123, 24'h000000, 1'b0, 1'b0, 25};
        tbl[8] = '{16'h7FFF, 16'h0001, 24'h7FFF00, 1'b0, 1'b0, 25};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(out_quotient), 32'd0);
        chk("reset flags", {30'd0, out_div0, out_ovf}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].dvd, tbl[i].dsr, tbl[i].q,
                      tbl[i].d0, tbl[i].ov, tbl[i].lat, 0);
        end

        // Back-to-back with the consumer always ready.
        ready_tie = 1'b1;
        out_ready = 1'b1;
        run_check("b2b first", 16'h0100, 16'h0200, 24'h000080, 1'b0, 1'b0, 25, 0);
        run_check("b2b second", 16'h0300, 16'hFF00, 24'hFFFD00, 1'b0, 1'b0, 25, 0);
        ready_tie = 1'b0;
        out_ready = 1'b0;

        // Backpressure for 7 cycles with an in_valid that must be ignored.
        run_check("bp", 16'h0100, 16'h0200, 24'h000080, 1'b0, 1'b0, 25, 7);

        // Saturating op leaves a non-zero quotient and ovf, then reset mid-CALC.
        run_check("pre-rst", 16'h8000, 16'hFFFF, 24'h7FFFFF, 1'b0, 1'b1, 25, 0);
        in_dividend = 16'h0100;
        in_divisor  = 16'h0100;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst quotient", 32'(out_quotient), 32'd0);
        chk("midrst flags", {30'd0, out_div0, out_ovf}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst aborted", 32'(out_valid), 32'd0);
        run_check("post-rst", 16'h0100, 16'h0100, 24'h000100, 1'b0, 1'b0, 25, 0);

        // Random operands against the integer model.
        for (int k = 0; k < 60; k++) begin
            rd = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rs = 16'h0000;
                1:       rs = 16'($urandom_range(1, 4));
                2:       rs = 16'hFFFF - 16'($urandom_range(0, 3));
                default: rs = 16'($urandom);
            endcase
            if (k % 11 == 0) rd = 16'h8000;
            model(rd, rs, mq, md0, mov);
            run_check($sformatf("rnd%0d", k), rd, rs, mq, md0, mov, md0 ? 1 : 25, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
